// File: rtl/usb_seg_pkg.sv
// Shared types and field layout for the segmented GPIF2 <-> memory DMA bridge.
package usb_seg_pkg;

  typedef enum logic [3:0] {
    DIR_IN  = 4'h4,
    DIR_OUT = 4'h8
  } dir_e;

  typedef enum logic [3:0] {
    ST_OK      = 4'd0,
    ST_BAD_SEG = 4'd1,
    ST_BAD_DIR = 4'd2,
    ST_RANGE   = 4'd3,
    ST_SHORT   = 4'd4
  } status_e;

  localparam int unsigned CMD_SEG_LSB = 0;
  localparam int unsigned CMD_DIR_LSB = 4;
  localparam int unsigned CMD_LEN_LSB = 8;
  localparam int unsigned CMD_LEN_W   = 24;
  localparam int unsigned RESP_W      = 32;

  function automatic logic [RESP_W-1:0] pack_resp(input status_e st, input logic [3:0] seg,
                                                  input logic [23:0] words_done);
    return {st, seg, words_done};
  endfunction

endpackage

// File: rtl/usb_seg_check.sv
// Combinational command validation: segment/direction/range decode and length resolution.
module usb_seg_check
  import usb_seg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned NUM_SEG = 6,
  parameter int unsigned LEN_W   = 24,
  parameter logic [NUM_SEG-1:0][ADDR_W-1:0] SEG_SIZE = '0
) (
  input  logic [3:0]       seg,
  input  logic [3:0]       dir,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] off,
  output status_e          status,
  output logic [LEN_W-1:0] len_res
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CW    = (ADDR_W > LEN_W + 1) ? ADDR_W : LEN_W + 1;

  logic              seg_ok;
  logic [ADDR_W-1:0] size_b;
  logic [CW-1:0]     size_w;
  logic [CW-1:0]     off_w;
  logic [CW-1:0]     len_w;
  logic [CW-1:0]     end_w;

  always_comb begin
    seg_ok = 1'b0;
    size_b = '0;
    for (int unsigned i = 1; i < NUM_SEG; i++) begin
      if (seg == 4'(i)) begin
        seg_ok = 1'b1;
        size_b = SEG_SIZE[i];
      end
    end
    size_w  = CW'(size_b / ADDR_W'(BYTES));
    off_w   = CW'(off);
    // size-off may wrap when off > size; the off >= size test below rejects that case first
    len_w   = (len == '0) ? (size_w - off_w) : CW'(len);
    end_w   = off_w + len_w;
    len_res = LEN_W'(len_w);

    if (!seg_ok)                              status = ST_BAD_SEG;
    else if (dir != DIR_IN && dir != DIR_OUT) status = ST_BAD_DIR;
    else if (off_w >= size_w || end_w > size_w) status = ST_RANGE;
    else                                      status = ST_OK;
  end

endmodule

// File: rtl/usb_seg_dma.sv
// Command-driven bridge moving words between GPIF2 streams and a segmented memory map,
// returning one status word per command.
module usb_seg_dma
  import usb_seg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned NUM_SEG = 6,
  parameter int unsigned LEN_W   = 24,
  parameter logic [NUM_SEG-1:0][ADDR_W-1:0] SEG_BASE = '0,
  parameter logic [NUM_SEG-1:0][ADDR_W-1:0] SEG_SIZE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_tdata,
  input  logic              cmd_tvalid,
  output logic              cmd_tready,
  output logic [DATA_W-1:0] resp_tdata,
  output logic              resp_tvalid,
  output logic              resp_tlast,
  input  logic              resp_tready,
  input  logic [DATA_W-1:0] tx_tdata,
  input  logic              tx_tvalid,
  input  logic              tx_tlast,
  output logic              tx_tready,
  output logic [DATA_W-1:0] rx_tdata,
  output logic              rx_tvalid,
  output logic              rx_tlast,
  input  logic              rx_tready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid
);

  localparam int unsigned BYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_CHECK,
    S_XFER_OUT,
    S_XFER_IN,
    S_RESP
  } state_e;

  state_e            state, state_nx;
  logic [3:0]        seg_q;
  logic [3:0]        dir_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  off_q;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic [23:0]       done;
  status_e           status_q;
  status_e           chk_status;
  logic [LEN_W-1:0]  chk_len;
  logic [ADDR_W-1:0] seg_base;
  logic [ADDR_W-1:0] addr_cur;
  logic              cmd_take;
  logic              beat;
  logic              rem_last;

  usb_seg_check #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_SEG (NUM_SEG),
    .LEN_W   (LEN_W),
    .SEG_SIZE(SEG_SIZE)
  ) u_check (
    .seg    (seg_q),
    .dir    (dir_q),
    .len    (len_q),
    .off    (off_q),
    .status (chk_status),
    .len_res(chk_len)
  );

  always_comb begin
    seg_base = '0;
    for (int unsigned i = 1; i < NUM_SEG; i++) begin
      if (seg_q == 4'(i)) seg_base = SEG_BASE[i];
    end
    addr_cur = seg_base + ptr * ADDR_W'(BYTES);
  end

  assign cmd_take = cmd_tvalid & cmd_tready;
  assign beat     = mem_wr | mem_rd;
  assign rem_last = (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (cmd_take) state_nx = S_HDR1;
      S_HDR1:     if (cmd_take) state_nx = S_CHECK;
      S_CHECK: begin
        if (chk_status != ST_OK)  state_nx = S_RESP;
        else if (dir_q == DIR_OUT) state_nx = S_XFER_OUT;
        else                       state_nx = S_XFER_IN;
      end
      S_XFER_OUT: if (beat && (rem_last || tx_tlast)) state_nx = S_RESP;
      S_XFER_IN:  if (beat && rem_last) state_nx = S_RESP;
      S_RESP:     if (resp_tready) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_tready  = 1'b0;
    resp_tdata  = '0;
    resp_tvalid = 1'b0;
    resp_tlast  = 1'b0;
    tx_tready   = 1'b0;
    rx_tdata    = '0;
    rx_tvalid   = 1'b0;
    rx_tlast    = 1'b0;
    mem_addr    = '0;
    mem_wr      = 1'b0;
    mem_wr_data = '0;
    mem_rd      = 1'b0;
    case (state)
      // ready is masked while rst is held so nothing looks accepted during reset
      S_IDLE, S_HDR1: cmd_tready = ~rst;
      S_XFER_OUT: begin
        tx_tready   = mem_wr_ready;
        mem_wr      = tx_tvalid & mem_wr_ready;
        mem_wr_data = mem_wr ? tx_tdata : '0;
        mem_addr    = addr_cur;
      end
      S_XFER_IN: begin
        rx_tvalid = mem_rd_valid;
        mem_rd    = mem_rd_valid & rx_tready;
        rx_tdata  = mem_rd_valid ? mem_rd_data : '0;
        rx_tlast  = mem_rd_valid & rem_last;
        mem_addr  = addr_cur;
      end
      S_RESP: begin
        resp_tvalid = 1'b1;
        resp_tlast  = 1'b1;
        resp_tdata  = DATA_W'(pack_resp(status_q, seg_q, done));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      dir_q     <= '0;
      len_q     <= '0;
      off_q     <= '0;
      ptr       <= '0;
      remaining <= '0;
      done      <= '0;
      status_q  <= ST_OK;
    end else begin
      if (state == S_IDLE && cmd_take) begin
        seg_q <= cmd_tdata[CMD_SEG_LSB +: 4];
        dir_q <= cmd_tdata[CMD_DIR_LSB +: 4];
        len_q <= LEN_W'(cmd_tdata[CMD_LEN_LSB +: CMD_LEN_W]);
      end
      if (state == S_HDR1 && cmd_take) off_q <= cmd_tdata[LEN_W-1:0];
      if (state == S_CHECK) begin
        ptr       <= ADDR_W'(off_q);
        remaining <= chk_len;
        done      <= '0;
        status_q  <= chk_status;
      end
      if (beat) begin
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        done      <= done + 24'd1;
        if (state == S_XFER_OUT && tx_tlast && !rem_last) status_q <= ST_SHORT;
      end
    end
  end

endmodule
